// File: rtl/pulse_stretch_mc_pkg.sv
// Shared types and defaults for the multi-channel pulse stretcher.
package pulse_stretch_mc_pkg;

    // Per-channel FSM state encoding, also visible to the bench.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_HOLD    = 2'd2
    } ps_state_e;

    localparam int unsigned CH_NUM_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 8;

endpackage

// File: rtl/pulse_stretch_ch.sv
// One pulse-stretch channel: IDLE -> STRETCH (L cycles) -> optional HOLD (H cycles).
module pulse_stretch_ch
    import pulse_stretch_mc_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [CNT_W-1:0] hold_i,
    input  logic             retrig_i,
    input  logic             miss_clr_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             miss_o
);

    ps_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             miss_q, miss_d;
    logic             miss_set;
    logic             pulse_q, busy_q;
    logic [CNT_W-1:0] len_m1, hold_m1;

    // len_i is already saturated to >= 1; hold_m1 is used only when hold_i > 0.
    assign len_m1  = len_i - CNT_W'(1);
    assign hold_m1 = hold_i - CNT_W'(1);

    // State, counter, sticky miss and registered output decode.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            miss_q  <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            pulse_q <= (state_d == ST_STRETCH);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next-state, counter update and miss detection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        miss_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_i) begin
                    state_d = ST_STRETCH;
                    cnt_d   = len_m1;
                end
            end
            ST_STRETCH: begin
                if (trig_i && retrig_i) begin
                    cnt_d = len_m1;
                end else if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    miss_set = trig_i;
                end else if (trig_i && (hold_i == '0)) begin
                    cnt_d = len_m1;
                end else if (hold_i != '0) begin
                    state_d  = ST_HOLD;
                    cnt_d    = hold_m1;
                    miss_set = trig_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                miss_set = trig_i;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // A fresh miss beats a simultaneous clear.
        miss_d = (miss_q & ~miss_clr_i) | miss_set;
    end

    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;
    assign miss_o  = miss_q;

endmodule

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: shared config fanned out to CH_NUM channels.
module pulse_stretch_mc
    import pulse_stretch_mc_pkg::*;
#(
    parameter int unsigned CH_NUM = CH_NUM_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] signal_in,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_hold,
    input  logic              cfg_retrig,
    input  logic              miss_clr,
    output logic [CH_NUM-1:0] signal_out,
    output logic [CH_NUM-1:0] busy,
    output logic [CH_NUM-1:0] miss
);

    logic [CNT_W-1:0] len_sat;

    // A programmed length of 0 behaves as a length of 1.
    assign len_sat = (cfg_len == '0) ? CNT_W'(1) : cfg_len;

    // One independent channel per trigger input.
    for (genvar g = 0; g < int'(CH_NUM); g++) begin : gen_ch
        pulse_stretch_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n_i    (rst),
            .trig_i     (signal_in[g]),
            .len_i      (len_sat),
            .hold_i     (cfg_hold),
            .retrig_i   (cfg_retrig),
            .miss_clr_i (miss_clr),
            .pulse_o    (signal_out[g]),
            .busy_o     (busy[g]),
            .miss_o     (miss[g])
        );
    end

endmodule
